// File: rtl/rv32_mem_access_unit_pkg.sv
// Shared types and constants for the rv32 memory access unit.
//   memory_access          : access-size encoding from the core's memory port
//   memory_exceptions      : fault mask type and bit masks returned with responses
//   memory_map             : bank decode constants (addr[31:28] selects the bank)
//   rv32_mem_access_unit_pkg : datapath widths local to this unit

package memory_access;
  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;
endpackage

package memory_exceptions;
  typedef logic [1:0] mem_exception_mask_t;
  localparam mem_exception_mask_t MEM_EX_MISALIGNED   = 2'b01;
  localparam mem_exception_mask_t MEM_EX_OUT_OF_RANGE = 2'b10;
endpackage

package memory_map;
  localparam int unsigned MEM_BANK_LSB  = 28;
  localparam int unsigned MEM_BANK_W    = 4;
  localparam logic [3:0]  MEM_BANK_RAM0 = 4'h1;
endpackage

package rv32_mem_access_unit_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
endpackage

// File: rtl/rv32_lane_merge.sv
// Little-endian lane steering for a 32-bit word.
//   word      : word read from RAM
//   data      : right-justified store data
//   access    : byte / half / word
//   offset    : byte offset addr[1:0] (half lane uses offset[1])
//   merged    : word with the target lane replaced by data (store path)
//   extracted : target lane of word, zero-extended (load path)
module rv32_lane_merge
  import memory_access::*;
  import rv32_mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] data,
  input  mem_access_t       access,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] extracted
);

  logic [4:0] byte_sh;
  logic [4:0] half_sh;

  assign byte_sh = {offset, 3'b000};
  assign half_sh = {offset[1], 4'b0000};

  // Word (and any encoding faulted upstream) passes straight through.
  always_comb begin
    merged    = data;
    extracted = word;
    case (access)
      MEM_ACCESS_BYTE: begin
        extracted = DATA_W'(BYTE_W'(word >> byte_sh));
        merged    = (word & ~(DATA_W'(32'h0000_00FF) << byte_sh))
                  | (DATA_W'(data[BYTE_W-1:0]) << byte_sh);
      end
      MEM_ACCESS_HALF: begin
        extracted = DATA_W'(HALF_W'(word >> half_sh));
        merged    = (word & ~(DATA_W'(32'h0000_FFFF) << half_sh))
                  | (DATA_W'(data[HALF_W-1:0]) << half_sh);
      end
      default: begin
        merged    = data;
        extracted = word;
      end
    endcase
  end

endmodule

// File: rtl/rv32_mem_access_unit.sv
// Memory-side bridge for the rv32i multicycle core. Accepts one load/store
// at a time, checks alignment and bank range, and drives a word-wide
// single-port synchronous RAM without byte strobes (sub-word stores are
// read-modify-write).
//   clk, rst          : clock, asynchronous active-low reset
//   req_*             : request handshake and payload from the core
//   rsp_valid/_rd_data/_exception : one-cycle response pulse
//   busy              : ~req_ready
//   ram_*             : RAM word address, read/write enables, write/read data
module rv32_mem_access_unit
  import memory_access::*;
  import memory_exceptions::*;
  import memory_map::*;
  import rv32_mem_access_unit_pkg::*;
#(
  parameter logic [3:0]  BANK_ID = MEM_BANK_RAM0,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_wr_ena,
  input  logic [DATA_W-1:0]   req_wr_data,
  input  mem_access_t         req_access,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rd_data,
  output mem_exception_mask_t rsp_exception,
  output logic                busy,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_rd_ena,
  output logic                ram_wr_ena,
  output logic [DATA_W-1:0]   ram_wr_data,
  input  logic [DATA_W-1:0]   ram_rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_MERGE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Address bits between the word index and the bank field must be zero.
  localparam logic [31:0] BELOW_BANK_MASK = (32'h1 << MEM_BANK_LSB) - 32'h1;
  localparam logic [31:0] IN_BANK_MASK    = (32'h1 << (ADDR_W + 2)) - 32'h1;
  localparam logic [31:0] HOLE_MASK       = BELOW_BANK_MASK & ~IN_BANK_MASK;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          off_q;
  logic                wr_q;
  logic [DATA_W-1:0]   data_q;
  mem_access_t         access_q;
  mem_exception_mask_t ex_q;

  logic                misaligned_c;
  logic                out_of_range_c;
  mem_exception_mask_t ex_c;
  logic                accept_c;
  logic [DATA_W-1:0]   merged_c;
  logic [DATA_W-1:0]   extracted_c;

  // Fault classification of the incoming request.
  always_comb begin
    case (req_access)
      MEM_ACCESS_BYTE: misaligned_c = 1'b0;
      MEM_ACCESS_HALF: misaligned_c = req_addr[0];
      MEM_ACCESS_WORD: misaligned_c = (req_addr[1:0] != 2'b00);
      default:         misaligned_c = 1'b1;
    endcase
  end

  assign out_of_range_c = (req_addr[MEM_BANK_LSB +: MEM_BANK_W] != BANK_ID)
                        || ((req_addr & HOLE_MASK) != 32'h0);
  assign ex_c     = (misaligned_c   ? MEM_EX_MISALIGNED   : '0)
                  | (out_of_range_c ? MEM_EX_OUT_OF_RANGE : '0);
  assign accept_c = req_valid && (state_q == ST_IDLE);

  // State and latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      off_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      access_q <= MEM_ACCESS_BYTE;
      ex_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        idx_q    <= req_addr[ADDR_W+1:2];
        off_q    <= req_addr[1:0];
        wr_q     <= req_wr_ena;
        data_q   <= req_wr_data;
        access_q <= req_access;
        ex_q     <= ex_c;
      end
    end
  end

  // Shared lane steering: extraction in RESP, merge in WRITE/MERGE.
  rv32_lane_merge u_lane_merge (
    .word      (ram_rd_data),
    .data      (data_q),
    .access    (access_q),
    .offset    (off_q),
    .merged    (merged_c),
    .extracted (extracted_c)
  );

  // Next state and outputs. Read data and merge data come from the RAM's
  // registered output, so those two paths are combinational by nature.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rd_data   = '0;
    rsp_exception = '0;
    ram_addr      = idx_q;
    ram_rd_ena    = 1'b0;
    ram_wr_ena    = 1'b0;
    ram_wr_data   = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (ex_c != '0)                                     state_d = ST_RESP;
          else if (req_wr_ena && req_access == MEM_ACCESS_WORD) state_d = ST_WRITE;
          else                                                state_d = ST_READ;
        end
      end
      ST_READ: begin
        ram_rd_ena = 1'b1;
        state_d    = wr_q ? ST_MERGE : ST_RESP;
      end
      ST_WRITE: begin
        ram_wr_ena  = 1'b1;
        ram_wr_data = merged_c;
        state_d     = ST_RESP;
      end
      ST_MERGE: begin
        ram_wr_ena  = 1'b1;
        ram_wr_data = merged_c;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid     = 1'b1;
        rsp_exception = ex_q;
        if (!wr_q && ex_q == '0) rsp_rd_data = extracted_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = ~req_ready;

endmodule

// File: doc/rv32_mem_access_unit.md
Name: rv32_mem_access_unit

Overview:
Memory-side bridge directly downstream of the rv32i multicycle core's memory port. Accepts one load/store request at a time over a valid/ready handshake and decodes the bank and in-bank word address. Drives a single-port, word-wide synchronous RAM that has no byte strobes, so sub-word stores are done as read-modify-write. Returns right-justified read data plus an exception mask to the core.

Parameters:
BANK_ID, 4'h1, value of addr[31:28] this unit serves; any other bank raises out-of-range.
ADDR_W, 10, RAM word-address width; depth is 2**ADDR_W words.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  unit can accept; high only in IDLE.
req_addr  in  32  byte address.
req_wr_ena  in  1  1 = store, 0 = load.
req_wr_data  in  32  store data, right-justified (low byte/half/word used).
req_access  in  mem_access_t  MEM_ACCESS_BYTE / MEM_ACCESS_HALF / MEM_ACCESS_WORD.
rsp_valid  out  1  one-cycle pulse: request complete.
rsp_rd_data  out  32  load data, zero-extended and right-justified; 0 for stores and faults.
rsp_exception  out  mem_exception_mask_t  fault bits, valid with rsp_valid; 0 otherwise.
busy  out  1  ~req_ready.
ram_addr  out  ADDR_W  RAM word address.
ram_rd_ena  out  1  RAM read; data appears on ram_rd_data in the following cycle.
ram_wr_ena  out  1  RAM full-word write this cycle.
ram_wr_data  out  32  RAM write word.
ram_rd_data  in  32  RAM read word; held stable until the next read.

Behaviour:
- Reset values (while rst low):
  - state = IDLE, req_ready = 1, rsp_valid = 0.
  - rsp_rd_data, rsp_exception, ram_addr, ram_wr_data = 0.
  - ram_rd_ena = ram_wr_ena = 0.
  - Assertion takes effect immediately, mid-operation included.
- Accept: on a rising edge with req_valid && req_ready, latch addr, wr_ena, wr_data and access. Call the accept cycle cycle 0.
- Fault check, evaluated at accept:
  - Misaligned (MEM_EX_MISALIGNED): half with addr[0] = 1, or word with addr[1:0] != 0.
  - Out-of-range (MEM_EX_OUT_OF_RANGE): addr[31:28] != BANK_ID, or addr[27:ADDR_W+2] != 0.
  - Both bits may be set together.
  - A faulting request goes straight to RESP: rsp_valid in cycle 1, no RAM enables at any point.
- Word index = addr[ADDR_W+1:2]. Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
- State machine: IDLE, READ, WRITE, MERGE, RESP.
  - Load: IDLE -> READ (cycle 1, ram_rd_ena = 1) -> RESP (cycle 2).
    - In RESP, rsp_rd_data = selected lane of ram_rd_data, zero-extended.
  - Word store: IDLE -> WRITE (cycle 1, ram_wr_ena = 1, ram_wr_data = wr_data) -> RESP (cycle 2).
  - Byte/half store: IDLE -> READ (cycle 1) -> MERGE (cycle 2) -> RESP (cycle 3).
    - In MERGE, ram_wr_ena = 1 and ram_wr_data = ram_rd_data with the target lane replaced by the low 8/16 bits of wr_data.
    - All other bytes are preserved.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- No response backpressure: the consumer must sample in the RESP cycle.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP.
- ram_addr is held at the latched word index from cycle 1 through RESP.
- req_* inputs are ignored while not in IDLE.
- Reset during READ of a sub-word store: no ram_wr_ena pulse occurs and RAM contents are unchanged.
- Reset during MERGE: ram_wr_ena drops asynchronously. Whether that partial-cycle write lands is defined by the RAM, not by this unit.
- Unrecognised req_access encoding: treated as misaligned fault.

Decomposition:
- mem_access_t (BYTE/HALF/WORD) lives in the memory_access package.
- MEM_EX_MISALIGNED and MEM_EX_OUT_OF_RANGE mask bits live in the memory_exceptions package.
- Bank constants live in memory_map.
- State enum is local to the module.
- One combinational sub-module, rv32_lane_merge: inputs (word, data, access, offset); outputs the merged word for stores and the extracted zero-extended lane for loads. It is shared by the READ/RESP and MERGE paths.

Test Plan:
1. Word store 0xDEADBEEF @0x10000010, then word load @0x10000010 -> store: ram_wr_ena in cycle 1 with ram_addr = 4, rsp_valid in cycle 2; load: rsp_valid in cycle 2 with rsp_rd_data = 0xDEADBEEF and exception = 0.
2. RAM word 4 = 0x11223344; byte store 0xAA @0x10000011 -> ram_rd_ena in cycle 1; ram_wr_ena in cycle 2 with 0x1122AA44; rsp_valid in cycle 3.
3. Half load @0x10000012 (word = 0x1122AA44) -> rsp_rd_data = 0x00001122 in cycle 2; byte load @0x10000013 -> 0x00000011.
4. Half load @0x10000011 -> rsp_valid in cycle 1 with MEM_EX_MISALIGNED set; ram_rd_ena and ram_wr_ena stay 0 throughout.
5. Word load @0x20000000 and @0x10001000 (ADDR_W = 10) -> MEM_EX_OUT_OF_RANGE set, rsp_valid in cycle 1, no RAM enables.
6. Byte store issued; rst pulled low during READ -> ram_wr_ena never asserts, req_ready = 1 immediately, RAM unchanged; a new request after release completes normally.
